// File: rtl/motor_output_guard_if.sv
// Signal bundle between the mixer/receiver side and the motor output guard.
// The master drives the motor targets and receiver/IMU status; the slave returns the guarded rates and state.
interface motor_output_guard_if #(
    parameter int RATE_W = 8
);
    logic [RATE_W-1:0] motor_1_rate_in;
    logic [RATE_W-1:0] motor_2_rate_in;
    logic [RATE_W-1:0] motor_3_rate_in;
    logic [RATE_W-1:0] motor_4_rate_in;
    logic [7:0]        throttle_val;
    logic              arm_req;
    logic              rx_activity;
    logic              imu_good;
    logic [RATE_W-1:0] motor_1_rate_out;
    logic [RATE_W-1:0] motor_2_rate_out;
    logic [RATE_W-1:0] motor_3_rate_out;
    logic [RATE_W-1:0] motor_4_rate_out;
    logic              armed;
    logic              failsafe;
    logic [1:0]        guard_state;

    modport master (
        output motor_1_rate_in, motor_2_rate_in, motor_3_rate_in, motor_4_rate_in,
        output throttle_val, arm_req, rx_activity, imu_good,
        input  motor_1_rate_out, motor_2_rate_out, motor_3_rate_out, motor_4_rate_out,
        input  armed, failsafe, guard_state
    );

    modport slave (
        input  motor_1_rate_in, motor_2_rate_in, motor_3_rate_in, motor_4_rate_in,
        input  throttle_val, arm_req, rx_activity, imu_good,
        output motor_1_rate_out, motor_2_rate_out, motor_3_rate_out, motor_4_rate_out,
        output armed, failsafe, guard_state
    );
endinterface

// File: rtl/motor_output_guard.sv
// Safety gate between the motor mixer and the PWM stage: arming sequence, per-motor slew
// limiting and an RX/IMU watchdog that ramps the motors down on signal loss.
module motor_output_guard #(
    parameter int RATE_W           = 8,
    parameter int ARM_HOLD_US      = 1000000,
    parameter int THROTTLE_ARM_MAX = 10,
    parameter int RX_TIMEOUT_US    = 100000,
    parameter int SLEW_PERIOD_US   = 1000,
    parameter int SLEW_STEP        = 4
) (
    input  logic             us_clk,
    input  logic             resetn,
    motor_output_guard_if.slave g
);
    localparam int HOLD_W = (ARM_HOLD_US > 1) ? $clog2(ARM_HOLD_US) : 1;
    localparam int WD_W   = $clog2(RX_TIMEOUT_US + 1);
    localparam int SLEW_W = (SLEW_PERIOD_US > 1) ? $clog2(SLEW_PERIOD_US) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ARM_HOLD_US - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(RX_TIMEOUT_US);
    localparam logic [SLEW_W-1:0] SLEW_LAST = SLEW_W'(SLEW_PERIOD_US - 1);
    localparam logic [RATE_W:0]   STEP_X    = (RATE_W + 1)'(SLEW_STEP);
    localparam logic [7:0]        THR_MAX   = 8'(THROTTLE_ARM_MAX);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMING   = 2'b01,
        ST_ARMED    = 2'b10,
        ST_FAILSAFE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [SLEW_W-1:0] slew_cnt_q, slew_cnt_d;
    logic              armed_q, armed_d;
    logic              failsafe_q, failsafe_d;
    logic [RATE_W-1:0] out_q    [4];
    logic [RATE_W-1:0] out_d    [4];
    logic [RATE_W-1:0] rate_in  [4];
    logic [RATE_W-1:0] tgt      [4];
    logic [RATE_W-1:0] slew_val [4];
    logic              slew_tick, wd_timeout, arm_ok, all_zero;

    // Step one output toward its target, working one bit wider so no result can wrap.
    function automatic logic [RATE_W-1:0] slew_toward(input logic [RATE_W-1:0] cur,
                                                      input logic [RATE_W-1:0] target);
        logic [RATE_W:0] c, t, r;
        c = {1'b0, cur};
        t = {1'b0, target};
        r = c;
        if (t > c) begin
            r = ((t - c) > STEP_X) ? (c + STEP_X) : t;
        end else if (c > t) begin
            r = ((c - t) > STEP_X) ? (c - STEP_X) : t;
        end
        return r[RATE_W-1:0];
    endfunction

    assign rate_in[0] = g.motor_1_rate_in;
    assign rate_in[1] = g.motor_2_rate_in;
    assign rate_in[2] = g.motor_3_rate_in;
    assign rate_in[3] = g.motor_4_rate_in;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slew
            assign tgt[gi]      = (state_q == ST_FAILSAFE) ? '0 : rate_in[gi];
            assign slew_val[gi] = slew_toward(out_q[gi], tgt[gi]);
        end
    endgenerate

    assign slew_tick  = (slew_cnt_q == SLEW_LAST);
    assign wd_timeout = (wd_cnt_q >= WD_LIMIT);
    assign arm_ok     = g.arm_req && (g.throttle_val <= THR_MAX) && g.imu_good && !wd_timeout;
    assign all_zero   = ~|{out_q[0], out_q[1], out_q[2], out_q[3]};

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        out_d      = out_q;
        slew_cnt_d = slew_tick ? '0 : slew_cnt_q + 1'b1;
        if (g.rx_activity) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q >= WD_LIMIT) begin
            wd_cnt_d = WD_LIMIT;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        case (state_q)
            ST_DISARMED: begin
                for (int i = 0; i < 4; i++) out_d[i] = '0;
                if (arm_ok) begin
                    state_d    = ST_ARMING;
                    hold_cnt_d = '0;
                end
            end
            ST_ARMING: begin
                for (int i = 0; i < 4; i++) out_d[i] = '0;
                if (!arm_ok) begin
                    state_d = ST_DISARMED;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_ARMED;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_ARMED: begin
                // Dropping the arm switch wins over any fault: cut outputs without a ramp.
                if (!g.arm_req) begin
                    state_d = ST_DISARMED;
                    for (int i = 0; i < 4; i++) out_d[i] = '0;
                end else begin
                    if (slew_tick) out_d = slew_val;
                    if (wd_timeout || !g.imu_good) state_d = ST_FAILSAFE;
                end
            end
            default: begin
                if (slew_tick) out_d = slew_val;
                if (all_zero && !g.arm_req) state_d = ST_DISARMED;
            end
        endcase

        armed_d    = (state_d == ST_ARMED);
        failsafe_d = (state_d == ST_FAILSAFE);
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_DISARMED;
            hold_cnt_q <= '0;
            wd_cnt_q   <= '0;
            slew_cnt_q <= '0;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b0;
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            slew_cnt_q <= slew_cnt_d;
            armed_q    <= armed_d;
            failsafe_q <= failsafe_d;
            for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
        end
    end

    assign g.motor_1_rate_out = out_q[0];
    assign g.motor_2_rate_out = out_q[1];
    assign g.motor_3_rate_out = out_q[2];
    assign g.motor_4_rate_out = out_q[3];
    assign g.armed            = armed_q;
    assign g.failsafe         = failsafe_q;
    assign g.guard_state      = state_q;
endmodule

// File: tb/tb_motor_output_guard.sv
// Randomized and directed bench for motor_output_guard, checked cycle by cycle against a
// behavioural model built from edge counts, "cycles since last frame" and signed rate arithmetic.
module tb_motor_output_guard;
    localparam int RW = 8, AH = 100, TM = 10, RTO = 50, SP = 4, SS = 4;

    logic          us_clk = 1'b0;
    logic          resetn = 1'b0;
    logic [RW-1:0] r_in [4];
    logic [7:0]    thr;
    logic          arm, rx, imu;
    bit            rx_en;
    int            total = 0, bad = 0, cyc = 0;

    // model: state uses the published guard_state codes (0 disarmed .. 3 failsafe)
    int m_state, m_since_rx, m_edges, m_arm_cycles;
    int m_out [4];

    always #5 us_clk = ~us_clk;

    motor_output_guard_if #(.RATE_W(RW)) bus ();

    assign bus.motor_1_rate_in = r_in[0];
    assign bus.motor_2_rate_in = r_in[1];
    assign bus.motor_3_rate_in = r_in[2];
    assign bus.motor_4_rate_in = r_in[3];
    assign bus.throttle_val    = thr;
    assign bus.arm_req         = arm;
    assign bus.rx_activity     = rx;
    assign bus.imu_good        = imu;

    motor_output_guard #(
        .RATE_W(RW), .ARM_HOLD_US(AH), .THROTTLE_ARM_MAX(TM),
        .RX_TIMEOUT_US(RTO), .SLEW_PERIOD_US(SP), .SLEW_STEP(SS)
    ) dut (
        .us_clk(us_clk),
        .resetn(resetn),
        .g(bus)
    );

    function automatic int move(int cur, int target);
        int d = target - cur;
        if (d > SS)  d = SS;
        if (d < -SS) d = -SS;
        return cur + d;
    endfunction

    task automatic model_reset();
        m_state = 0; m_since_rx = 0; m_edges = 0; m_arm_cycles = 0;
        m_out = '{default: 0};
    endtask

    task automatic model_update();
        bit t, to, ok, allz;
        if (!resetn) begin
            model_reset();
            return;
        end
        t    = (m_edges % SP) == SP - 1;
        to   = m_since_rx >= RTO;
        ok   = arm && (int'(thr) <= TM) && imu && !to;
        allz = (m_out[0] == 0) && (m_out[1] == 0) && (m_out[2] == 0) && (m_out[3] == 0);
        case (m_state)
            0: begin
                m_out = '{default: 0};
                if (ok) begin m_state = 1; m_arm_cycles = 0; end
            end
            1: begin
                m_out = '{default: 0};
                if (!ok) m_state = 0;
                else begin
                    m_arm_cycles++;
                    if (m_arm_cycles == AH) m_state = 2;
                end
            end
            2: begin
                if (!arm) begin
                    m_state = 0;
                    m_out = '{default: 0};
                end else begin
                    if (t) for (int i = 0; i < 4; i++) m_out[i] = move(m_out[i], int'(r_in[i]));
                    if (to || !imu) m_state = 3;
                end
            end
            default: begin
                if (t) for (int i = 0; i < 4; i++) m_out[i] = move(m_out[i], 0);
                if (allz && !arm) m_state = 0;
            end
        endcase
        m_since_rx = rx ? 0 : ((m_since_rx >= RTO) ? RTO : m_since_rx + 1);
        m_edges++;
    endtask

    function automatic logic [35:0] obs();
        return {bus.armed, bus.failsafe, bus.guard_state, bus.motor_1_rate_out,
                bus.motor_2_rate_out, bus.motor_3_rate_out, bus.motor_4_rate_out};
    endfunction

    function automatic logic [35:0] expv();
        return {(m_state == 2), (m_state == 3), 2'(m_state), 8'(m_out[0]),
                8'(m_out[1]), 8'(m_out[2]), 8'(m_out[3])};
    endfunction

    // One clock: model follows the edge, next inputs are set on the falling edge.
    task automatic tick();
        @(posedge us_clk);
        model_update();
        @(negedge us_clk);
        cyc++;
        rx = rx_en && (cyc % 10 == 0);
    endtask

    function automatic logic [31:0] outs_all();
        return {bus.motor_1_rate_out, bus.motor_2_rate_out, bus.motor_3_rate_out, bus.motor_4_rate_out};
    endfunction

    task automatic set_rates(input int v);
        for (int i = 0; i < 4; i++) r_in[i] = 8'(v);
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (bus.guard_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", bus.guard_state); end
        total++; if (bus.armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b want=0", bus.armed); end
        total++; if (bus.failsafe !== 1'b0) begin bad++; $display("FAIL reset_failsafe got=%b want=0", bus.failsafe); end
        total++; if (outs_all() !== 32'h0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs_all()); end
        resetn = 1'b1;
        model_reset();
        $display("reset: released at cyc=%0d", cyc);
    endtask

    task automatic test_arm();
        bit seen_arming = 0;
        arm = 1'b1; thr = 8'd5; imu = 1'b1; set_rates(0);
        for (int k = 0; k < 110; k++) begin
            tick();
            if (bus.guard_state === 2'b01) seen_arming = 1;
            total++; if (obs() !== expv()) begin bad++; $display("FAIL arm cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        total++;
        if (!(seen_arming && bus.guard_state === 2'b10 && bus.armed === 1'b1 && outs_all() === 32'h0)) begin
            bad++; $display("FAIL arm_final seen_arming=%0d got_state=%b armed=%b outs=%h want 10/1/0", seen_arming, bus.guard_state, bus.armed, outs_all());
        end
        $display("arm: state=%b armed=%b", bus.guard_state, bus.armed);
    endtask

    task automatic test_abort();
        arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL abort_disarm cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        arm = 1'b1; thr = 8'd5;
        for (int k = 0; k < 60; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL abort_hold cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        thr = 8'd20;
        for (int k = 0; k < 2; k++) tick();
        total++; if (bus.guard_state !== 2'b00) begin bad++; $display("FAIL abort_state got=%b want=00", bus.guard_state); end
        thr = 8'd5;
        for (int k = 0; k < 60; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL abort_retry cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        total++; if (bus.guard_state !== 2'b01) begin bad++; $display("FAIL abort_restart got=%b want=01", bus.guard_state); end
        for (int k = 0; k < 50; k++) tick();
        total++; if (bus.armed !== 1'b1) begin bad++; $display("FAIL abort_rearm got=%b want=1", bus.armed); end
        $display("abort: rearmed state=%b", bus.guard_state);
    endtask

    task automatic test_slew();
        set_rates(40);
        for (int k = 0; k < 44; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL slew_up cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        total++; if (outs_all() !== {4{8'd40}}) begin bad++; $display("FAIL slew_40 got=%h want=28282828", outs_all()); end
        set_rates(38);
        for (int k = 0; k < 4; k++) tick();
        total++; if (outs_all() !== {4{8'd38}}) begin bad++; $display("FAIL slew_38 got=%h want=26262626", outs_all()); end
        for (int r = 0; r < 24; r++) begin
            int n;
            case (r)
                0: set_rates(255);
                1: set_rates(0);
                default: for (int i = 0; i < 4; i++) r_in[i] = 8'($urandom_range(0, 255));
            endcase
            thr = 8'($urandom_range(0, 255));
            n = (r < 2) ? 300 : int'($urandom_range(4, 60));
            for (int k = 0; k < n; k++) begin
                tick();
                total++; if (obs() !== expv()) begin bad++; $display("FAIL slew_rand r=%0d cyc=%0d got=%h want=%h", r, cyc, obs(), expv()); end
            end
            $display("slew round %0d: cycles=%0d outs=%h", r, n, outs_all());
        end
    endtask

    task automatic test_rx_loss();
        set_rates(40);
        for (int k = 0; k < 300; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rxloss_settle cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        rx_en = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rxloss_ramp cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        total++;
        if (bus.failsafe !== 1'b1 || bus.guard_state !== 2'b11 || outs_all() !== 32'h0) begin
            bad++; $display("FAIL rxloss_fs failsafe=%b state=%b outs=%h want 1/11/0", bus.failsafe, bus.guard_state, outs_all());
        end
        rx_en = 1;
        for (int k = 0; k < 30; k++) tick();
        total++; if (bus.guard_state !== 2'b11) begin bad++; $display("FAIL rxloss_sticky got=%b want=11", bus.guard_state); end
        arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL rxloss_exit cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        total++; if (bus.guard_state !== 2'b00) begin bad++; $display("FAIL rxloss_disarm got=%b want=00", bus.guard_state); end
        for (int k = 0; k < 30; k++) tick();
        total++; if (bus.guard_state !== 2'b00) begin bad++; $display("FAIL rxloss_stay got=%b want=00", bus.guard_state); end
        $display("rx_loss: final state=%b", bus.guard_state);
    endtask

    task automatic test_priority();
        arm = 1'b1; thr = 8'd5; imu = 1'b1; set_rates(0);
        for (int k = 0; k < 110; k++) tick();
        set_rates(40);
        for (int k = 0; k < 50; k++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL prio_ramp cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        imu = 1'b0; arm = 1'b0;
        tick();
        total++;
        if (bus.guard_state !== 2'b00 || outs_all() !== 32'h0 || bus.failsafe !== 1'b0) begin
            bad++; $display("FAIL prio_cut state=%b outs=%h failsafe=%b want 00/0/0", bus.guard_state, outs_all(), bus.failsafe);
        end
        imu = 1'b1;
        $display("priority: state=%b outs=%h", bus.guard_state, outs_all());
    endtask

    task automatic test_async_reset();
        int k = 0;
        arm = 1'b1; thr = 8'd5; set_rates(0);
        for (int j = 0; j < 110; j++) tick();
        set_rates(40);
        while (m_out[0] != 20 && k < 60) begin
            tick();
            k++;
            total++; if (obs() !== expv()) begin bad++; $display("FAIL areset_ramp cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        total++; if (outs_all() !== {4{8'd20}}) begin bad++; $display("FAIL areset_mid got=%h want=14141414", outs_all()); end
        #2 resetn = 1'b0;
        #1;
        total++; if (outs_all() !== 32'h0) begin bad++; $display("FAIL areset_outs got=%h want=0", outs_all()); end
        total++; if (bus.guard_state !== 2'b00 || bus.armed !== 1'b0) begin bad++; $display("FAIL areset_state got=%b armed=%b want=00/0", bus.guard_state, bus.armed); end
        @(negedge us_clk);
        resetn = 1'b1;
        model_reset();
        for (int j = 0; j < 20; j++) begin
            tick();
            total++; if (obs() !== expv()) begin bad++; $display("FAIL areset_after cyc=%0d got=%h want=%h", cyc, obs(), expv()); end
        end
        $display("async_reset: state=%b outs=%h", bus.guard_state, outs_all());
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int n = int'($urandom_range(20, 150));
            for (int i = 0; i < 4; i++) r_in[i] = 8'($urandom_range(0, 255));
            arm   = ($urandom_range(0, 5) != 0);
            imu   = ($urandom_range(0, 7) != 0);
            rx_en = ($urandom_range(0, 4) != 0);
            thr   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, 10));
            for (int k = 0; k < n; k++) begin
                tick();
                total++; if (obs() !== expv()) begin bad++; $display("FAIL random r=%0d cyc=%0d got=%h want=%h", r, cyc, obs(), expv()); end
            end
            $display("random round %0d: cycles=%0d state=%b outs=%h", r, n, bus.guard_state, outs_all());
        end
    endtask

    initial begin
        arm = 1'b0; thr = 8'd0; imu = 1'b1; rx = 1'b0; rx_en = 1;
        set_rates(0);
        model_reset();
        test_reset();
        test_arm();
        test_abort();
        test_slew();
        test_rx_loss();
        test_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
